// File: rtl/alu_seq.sv
// Bus ALU with accumulator A, result register G (tri-stated onto Q), registered
// {Z,N,C,V} flags and iterative one-bit-per-cycle logical shifts with Busy/Done.
module alu_seq #(
  parameter int WIDTH = 10
) (
  input  logic             CLKb,
  input  logic             Reset,
  input  logic [WIDTH-1:0] OP,
  input  logic [2:0]       ALUControl,
  input  logic             Ain,
  input  logic             Gin,
  input  logic             Gout,
  output logic [WIDTH-1:0] Q,
  output logic             Busy,
  output logic             Done,
  output logic [3:0]       Flags
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NEG = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] a_reg, g_reg, w_reg;
  logic [SHW-1:0]   cnt;
  logic             c_acc;
  logic             shr_dir;
  logic             done_reg;
  logic [3:0]       flags_reg;

  op_t              op_sel;
  logic [WIDTH:0]   sum_add, sum_sub;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic             is_shift;
  logic             cnt_zero;

  assign op_sel   = op_t'(ALUControl);
  assign is_shift = (op_sel == OP_SHL) || (op_sel == OP_SHR);
  assign cnt_zero = (cnt == '0);

  // Carry and borrow both come from the extra top bit of a WIDTH+1 operation.
  always_comb begin
    sum_add = {1'b0, a_reg} + {1'b0, OP};
    sum_sub = {1'b0, a_reg} - {1'b0, OP};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_sel)
      OP_ADD: begin
        alu_res = sum_add[WIDTH-1:0];
        alu_c   = sum_add[WIDTH];
        alu_v   = (a_reg[WIDTH-1] == OP[WIDTH-1]) && (alu_res[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sum_sub[WIDTH-1:0];
        alu_c   = sum_sub[WIDTH];
        alu_v   = (a_reg[WIDTH-1] != OP[WIDTH-1]) && (alu_res[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_NEG: begin
        alu_res = '0 - OP;
        alu_c   = |OP;
        alu_v   = OP[WIDTH-1] && !(|OP[WIDTH-2:0]);
      end
      OP_AND:  alu_res = a_reg & OP;
      OP_OR:   alu_res = a_reg | OP;
      OP_XOR:  alu_res = a_reg ^ OP;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge CLKb or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Gin && is_shift) next_state = SHIFT;
      SHIFT:   if (cnt_zero)        next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLKb or posedge Reset) begin
    if (Reset) begin
      a_reg     <= '0;
      g_reg     <= '0;
      w_reg     <= '0;
      cnt       <= '0;
      c_acc     <= 1'b0;
      shr_dir   <= 1'b0;
      done_reg  <= 1'b0;
      flags_reg <= '0;
    end else begin
      done_reg <= (state == SHIFT) && cnt_zero;
      if (state == IDLE) begin
        if (Ain) a_reg <= OP;
        if (Gin) begin
          if (is_shift) begin
            w_reg   <= a_reg;
            cnt     <= OP[SHW-1:0];
            c_acc   <= 1'b0;
            shr_dir <= ALUControl[0];
          end else begin
            g_reg     <= alu_res;
            flags_reg <= {alu_res == '0, alu_res[WIDTH-1], alu_c, alu_v};
          end
        end
      end else if (!cnt_zero) begin
        if (shr_dir) begin
          w_reg <= w_reg >> 1;
          c_acc <= w_reg[0];
        end else begin
          w_reg <= w_reg << 1;
          c_acc <= w_reg[WIDTH-1];
        end
        cnt <= cnt - SHW'(1);
      end else begin
        g_reg     <= w_reg;
        flags_reg <= {w_reg == '0, w_reg[WIDTH-1], c_acc, 1'b0};
      end
    end
  end

  assign Busy  = (state == SHIFT);
  assign Done  = done_reg;
  assign Flags = flags_reg;
  assign Q     = Gout ? g_reg : 'z;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised scoreboard bench for alu_seq: stimulus pushes model results,
// a negedge monitor pops and compares whenever a result is presented.
module tb_alu_seq;
  localparam int W    = 10;
  localparam int SHW  = $clog2(W);
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst, gin, ain, gout;
  logic [W-1:0] op;
  logic [2:0]   ctl;
  logic [W-1:0] q;
  logic         busy, done;
  logic [3:0]   flags;

  typedef struct {
    int    g;
    int    f;
    string name;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_a  = 0;
  logic pend     = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .CLKb(clk), .Reset(rst), .OP(op), .ALUControl(ctl), .Ain(ain), .Gin(gin),
    .Gout(gout), .Q(q), .Busy(busy), .Done(done), .Flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
  endfunction

  function automatic int ovf(input int s);
    return (s > (1 << (W - 1)) - 1 || s < -(1 << (W - 1))) ? 1 : 0;
  endfunction

  function automatic string opname(input int c);
    case (c)
      0: return "ADD"; 1: return "SUB"; 2: return "NEG"; 3: return "AND";
      4: return "OR";  5: return "XOR"; 6: return "SHL"; default: return "SHR";
    endcase
  endfunction

  function automatic exp_t model(input int c, input int a, input int b);
    exp_t e;
    int g, cy, v, amt;
    g = 0; cy = 0; v = 0;
    amt = b & ((1 << SHW) - 1);
    case (c)
      0: begin g = (a + b) & MASK; cy = (a + b) >> W; v = ovf(sx(a) + sx(b)); end
      1: begin g = (a - b) & MASK; cy = (a < b) ? 1 : 0; v = ovf(sx(a) - sx(b)); end
      2: begin g = (-b) & MASK; cy = (b != 0) ? 1 : 0; v = ovf(-sx(b)); end
      3: g = a & b;
      4: g = a | b;
      5: g = a ^ b;
      6: begin
        g  = (amt >= W) ? 0 : (a << amt) & MASK;
        cy = (amt == 0 || amt > W) ? 0 : (a >> (W - amt)) & 1;
      end
      default: begin
        g  = (amt >= W) ? 0 : a >> amt;
        cy = (amt == 0 || amt > W) ? 0 : (a >> (amt - 1)) & 1;
      end
    endcase
    e.g    = g;
    e.f    = ((g == 0 ? 1 : 0) << 3) | (((g >> (W - 1)) & 1) << 2) | (cy << 1) | v;
    e.name = opname(c);
    return e;
  endfunction

  // Monitor: a result is presented the negedge after an IDLE Gin of a
  // single-cycle op, or whenever Done is high.
  always @(negedge clk) begin
    if (pend || done) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got G=0x%0h flags=0x%0h, required no result", q, flags);
      end else begin
        mon_e = sbq.pop_front();
        check({mon_e.name, "_G"}, int'(q), mon_e.g);
        check({mon_e.name, "_flags"}, int'(flags), mon_e.f);
        if (pend) begin
          check({mon_e.name, "_busy"}, int'(busy), 0);
          check({mon_e.name, "_done"}, int'(done), 0);
        end
      end
    end
    pend = gin && !busy && (ctl < 3'd6) && !rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int v);
    ain = 1'b1; op = W'(v);
    step();
    ain = 1'b0;
    model_a = v;
  endtask

  task automatic run_op(input int c, input int b, input bit with_ain, input bit junk);
    int amt, cnt;
    sbq.push_back(model(c, model_a, b));
    ctl = 3'(c); op = W'(b); gin = 1'b1; ain = with_ain;
    step();
    gin = 1'b0; ain = 1'b0;
    if (with_ain) model_a = b;
    if (c >= 6) begin
      amt = b & ((1 << SHW) - 1);
      cnt = 0;
      while (busy && cnt < 40) begin
        cnt++;
        if (junk) begin
          ain = 1'($urandom); gin = 1'($urandom);
          op = W'($urandom); ctl = 3'($urandom);
        end
        step();
      end
      ain = 1'b0; gin = 1'b0;
      check({opname(c), "_busy_cycles"}, cnt, amt + 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, %0d entries pending", sbq.size());
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; gout = 1'b0; gin = 1'b0; ain = 1'b0; op = '0; ctl = '0;
    repeat (2) @(negedge clk);
    check("reset_flags", int'(flags), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    step();
    rst = 1'b0; gout = 1'b1;
    #1;
    check("reset_q", int'(q), 0);
    step();

    load('h3FF); run_op(0, 'h001, 0, 0);
    load('h200); run_op(1, 'h001, 0, 0);
    run_op(2, 'h200, 0, 0);
    load('h001); run_op(6, 3, 0, 1);
    run_op(0, 'h000, 0, 0);
    load('h201); run_op(7, 0, 0, 0);
    run_op(7, 12, 0, 0);
    run_op(5, 'h155, 1, 0);
    run_op(3, 'h0F0, 0, 0);
    run_op(6, 10, 0, 0);
    step();

    // Reset mid-run with the bus released.
    gout = 1'b0; rst = 1'b1;
    step();
    check("midreset_flags", int'(flags), 0);
    check("midreset_busy", int'(busy), 0);
    rst = 1'b0; gout = 1'b1; model_a = 0;
    #1;
    check("midreset_q", int'(q), 0);
    step();

    // Reset on the third busy cycle of a shift aborts it with no Done.
    load('h3FF);
    ctl = 3'd6; op = W'(5); gin = 1'b1;
    step();
    gin = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_q", int'(q), 0);
    check("abort_flags", int'(flags), 0);
    #2;
    rst = 1'b0; model_a = 0;
    repeat (8) step();
    run_op(0, 'h123, 0, 0);
    load('h07F); run_op(0, 'h001, 0, 0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) load(int'($urandom & MASK));
      run_op(int'($urandom_range(0, 7)), int'($urandom & MASK),
             $urandom_range(0, 3) == 0, 1'($urandom));
    end

    repeat (4) step();
    check("scoreboard_drain", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
